// File: rtl/truth_table_checker.sv
// truth_table_checker
//   On-chip exhaustive checker for a small combinational DUT. It drives every
//   input vector onto vec_out in binary order. After a fixed settle time it
//   samples NUM_RESP response bits, which must all agree. It reports
//   pass/fail, the first disagreeing vector, a saturating mismatch count and
//   the truth table seen on resp_in[0].
//
//   Every vector takes SETTLE+2 cycles: one APPLY cycle, SETTLE cycles of
//   settling, then one SAMPLE cycle. With the defaults, a sweep needs
//   8 x 4 = 32 cycles from the start-sampling edge to done.
//
//   Optional build macro: TTC_STOP_ON_FAIL_EN
//     defined   - the first mismatching vector ends the sweep (DONE, pass=0,
//                 fail_count=1, vec_out holds the failing vector).
//     undefined - all 2^NUM_IN vectors are swept and every mismatch is counted.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; aborts any sweep, zeroes outputs
//   start       starts a sweep when sampled high in IDLE or DONE
//   vec_out     [NUM_IN]      vector driven to the DUT
//   resp_in     [NUM_RESP]    DUT responses, looked at only in SAMPLE
//   busy        high in APPLY / SETTLE / SAMPLE
//   done        high in DONE until the next start or reset
//   pass        valid with done; 1 iff no vector disagreed
//   first_fail  [NUM_IN]      first disagreeing vector (0 if none)
//   fail_count  [NUM_IN+1]    disagreeing vectors, saturating at 2^NUM_IN
//   tt_out      [2^NUM_IN]    bit i = resp_in[0] sampled at vector i
module truth_table_checker #(
  parameter int NUM_IN   = 3,
  parameter int NUM_RESP = 6,
  parameter int SETTLE   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [NUM_IN-1:0]        vec_out,
  input  logic [NUM_RESP-1:0]      resp_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_IN-1:0]        first_fail,
  output logic [NUM_IN:0]          fail_count,
  output logic [(1<<NUM_IN)-1:0]   tt_out
);

  localparam int NVEC = 1 << NUM_IN;
  // The counter only has to hold SETTLE-1.
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [NUM_IN:0]   FC_MAX   = (NUM_IN+1)'(NVEC);
  localparam logic [NUM_IN-1:0] VEC_LAST = '1;
  localparam logic [CW-1:0]     CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            failed;     // a mismatch has been seen in this sweep

  // The responses agree when they are all zeros or all ones.
  logic            agree;
  assign agree = (&resp_in) | ~(|resp_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      failed     <= 1'b0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      first_fail <= '0;
      fail_count <= '0;
      tt_out     <= '0;
    end else begin
      case (state)
        // A start here clears every result of the previous sweep. The
        // result registers therefore only ever describe one sweep.
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_out    <= '0;
            fail_count <= '0;
            first_fail <= '0;
            tt_out     <= '0;
            failed     <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_APPLY;
          end
        end

        S_APPLY: begin
          settle_cnt <= CNT_LOAD;
          state      <= S_SETTLE;
        end

        // This state lasts exactly SETTLE cycles. The counter is loaded
        // with SETTLE-1, and the exit is taken in the cycle it reads zero.
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        S_SAMPLE: begin
          tt_out[vec_out] <= resp_in[0];
          if (!agree) begin
            if (fail_count != FC_MAX) begin
              fail_count <= fail_count + 1'b1;
            end
            if (!failed) begin
              first_fail <= vec_out;
            end
            failed <= 1'b1;
          end
`ifdef TTC_STOP_ON_FAIL_EN
          // The first mismatch ends the sweep. vec_out keeps the failing
          // vector, so it can be read off the board.
          if (!agree || vec_out == VEC_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= agree & ~failed;
          end else begin
            vec_out <= vec_out + 1'b1;
            state   <= S_APPLY;
          end
`else
          if (vec_out == VEC_LAST) begin
            // vec_out stays at all ones until the next start.
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            // This sample has not been folded into 'failed' yet.
            pass  <= agree & ~failed;
          end else begin
            vec_out <= vec_out + 1'b1;
            state   <= S_APPLY;
          end
`endif
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
